// File: rtl/uart_alu_requester.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_requester
// Purpose  : Sends A, B, opcode over a UART FIFO pair and waits for the result byte.
// Revision : 1.0
// ============================================================================
module uart_alu_requester #(
    parameter int DATA_BITS   = 8,
    parameter int OPCODE_BITS = 6,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_BITS-1:0]   i_op_a,
    input  logic [DATA_BITS-1:0]   i_op_b,
    input  logic [OPCODE_BITS-1:0] i_op_code,
    input  logic                   i_tx_full,
    input  logic                   i_rx_empty,
    input  logic [DATA_BITS-1:0]   i_r_data,
    output logic [DATA_BITS-1:0]   o_w_data,
    output logic                   o_wr_uart,
    output logic                   o_rd_uart,
    output logic [DATA_BITS-1:0]   o_result,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_timeout
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT_RX = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   op_a_q, op_a_d;
    logic [DATA_BITS-1:0]   op_b_q, op_b_d;
    logic [OPCODE_BITS-1:0] op_code_q, op_code_d;
    logic [1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   result_q, result_d;
    logic [DATA_BITS-1:0]   tx_byte;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_code_q <= '0;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_code_q <= op_code_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    tx_byte = op_a_q;
            2'd1:    tx_byte = op_b_q;
            default: tx_byte = DATA_BITS'(op_code_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_code_d = op_code_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        o_w_data  = '0;
        o_wr_uart = 1'b0;
        o_rd_uart = 1'b0;
        o_done    = 1'b0;
        o_timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stale bytes are drained before a request may begin.
                if (!i_rx_empty) begin
                    o_rd_uart = 1'b1;
                end else if (i_start) begin
                    op_a_d    = i_op_a;
                    op_b_d    = i_op_b;
                    op_code_d = i_op_code;
                    idx_d     = 2'd0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                o_w_data = tx_byte;
                if (!i_tx_full) begin
                    o_wr_uart = 1'b1;
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                        state_d = S_WAIT_RX;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WAIT_RX: begin
                // An arriving byte wins over an expiring counter.
                if (!i_rx_empty) begin
                    result_d  = i_r_data;
                    o_rd_uart = 1'b1;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    o_timeout = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        if (i_reset) begin
            o_w_data  = '0;
            o_wr_uart = 1'b0;
            o_rd_uart = 1'b0;
            o_done    = 1'b0;
            o_timeout = 1'b0;
        end
    end

    assign o_result = result_q;
    assign o_busy   = (state_q != S_IDLE) && !i_reset;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_requester
// Purpose  : Scoreboard bench for uart_alu_requester with a modelled RX FIFO.
// Revision : 1.0
// ============================================================================
module tb_uart_alu_requester;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [5:0] op = 6'h00;
    logic       tx_full = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    wire  [7:0] w_data, result;
    wire        wr, rd, busy, done, tmo;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] exp_b;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, to_cnt = 0, pops = 0;
    int last_wr_cyc = 0, done_cyc = 0, to_cyc = 0;

    uart_alu_requester #(
        .DATA_BITS   (8),
        .OPCODE_BITS (6),
        .TIMEOUT     (TO)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_op_a     (a),
        .i_op_b     (b),
        .i_op_code  (op),
        .i_tx_full  (tx_full),
        .i_rx_empty (rx_empty),
        .i_r_data   (r_data),
        .o_w_data   (w_data),
        .o_wr_uart  (wr),
        .o_rd_uart  (rd),
        .o_result   (result),
        .o_busy     (busy),
        .o_done     (done),
        .o_timeout  (tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write scoreboard and strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            n_cmp++;
            if (txq.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got %h, no byte expected", w_data);
            end else begin
                exp_b = txq.pop_front();
                if (w_data !== exp_b) begin
                    n_err++;
                    $display("FAIL tx_byte: got %h expected %h", w_data, exp_b);
                end
            end
            if (tx_full) begin
                n_err++;
                $display("FAIL tx_while_full: wr=%b with tx_full=%b", wr, tx_full);
            end
        end
        if (rd) rd_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (tmo) begin to_cnt++; to_cyc = cyc; end
        if (wr && rd) begin
            n_err++;
            $display("FAIL wr_rd_overlap: wr=%b rd=%b", wr, rd);
        end
        if (done && tmo) begin
            n_err++;
            $display("FAIL done_timeout_overlap: done=%b timeout=%b", done, tmo);
        end
    end

    // RX FIFO model: applies pops and refreshes the head after each edge.
    always @(posedge clk) begin
        #2;
        while (pops < rd_cnt) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            pops++;
        end
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [5:0] iop);
        txq.push_back(ia);
        txq.push_back(ib);
        txq.push_back({2'b00, iop});
        a = ia; b = ib; op = iop; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++;
        if ({busy, wr, rd, done, tmo} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 00000", {busy, wr, rd, done, tmo});
        end
        n_cmp++;
        if (result !== 8'h00 || w_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: got result=%h w_data=%h expected 00 00", result, w_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int w0 = wr_cnt, d0 = done_cnt, r0 = rd_cnt, t0 = to_cnt;
        issue(8'h05, 8'h03, 6'h20);
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        n_cmp++;
        if (wr_cnt !== w0 + 3) begin
            n_err++;
            $display("FAIL basic_writes: got %0d expected 3", wr_cnt - w0);
        end
        rxq.push_back(8'h08);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick(); tick();
        n_cmp++;
        if (result !== 8'h08) begin
            n_err++;
            $display("FAIL basic_result: got %h expected 08", result);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || rd_cnt - r0 !== 1 || to_cnt !== t0) begin
            n_err++;
            $display("FAIL basic_pulses: got done=%0d pops=%0d to=%0d expected 1 1 0",
                     done_cnt - d0, rd_cnt - r0, to_cnt - t0);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_latency();
        int w0 = wr_cnt, d0 = done_cnt;
        int c0 = cyc;
        issue(8'h21, 8'h43, 6'h01);
        for (int i = 0; i < 20 && wr_cnt < w0 + 1; i++) tick();
        rxq.push_back(8'h64);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick();
        n_cmp++;
        if (done_cnt == d0 || done_cyc - c0 !== 5) begin
            n_err++;
            $display("FAIL latency: got %0d cycles expected 5", done_cyc - c0);
        end
        n_cmp++;
        if (result !== 8'h64) begin
            n_err++;
            $display("FAIL latency_result: got %h expected 64", result);
        end
    endtask

    task automatic test_backpressure();
        int w0 = wr_cnt, d0 = done_cnt;
        issue(8'hAA, 8'h55, 6'h24);
        for (int i = 0; i < 20 && wr_cnt < w0 + 1; i++) tick();
        tx_full = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (wr_cnt !== w0 + 1) begin
            n_err++;
            $display("FAIL bp_hold: got %0d writes expected 1", wr_cnt - w0);
        end
        tx_full = 1'b0;
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        rxq.push_back(8'h79);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick(); tick();
        n_cmp++;
        if (wr_cnt !== w0 + 3 || result !== 8'h79) begin
            n_err++;
            $display("FAIL bp_total: got writes=%0d result=%h expected 3 79", wr_cnt - w0, result);
        end
    endtask

    task automatic test_timeout();
        int w0 = wr_cnt, d0 = done_cnt, t0 = to_cnt;
        logic [7:0] prev = result;
        issue(8'h0F, 8'hF0, 6'h3A);
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        for (int i = 0; i < 40 && to_cnt == t0; i++) tick();
        n_cmp++;
        if (to_cnt - t0 !== 1 || to_cyc - last_wr_cyc !== TO) begin
            n_err++;
            $display("FAIL timeout_time: got pulses=%0d delay=%0d expected 1 %0d",
                     to_cnt - t0, to_cyc - last_wr_cyc, TO);
        end
        tick();
        n_cmp++;
        if (done_cnt !== d0 || result !== prev || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_state: got done=%0d result=%h busy=%b expected 0 %h 0",
                     done_cnt - d0, result, busy, prev);
        end
    endtask

    task automatic test_timeout_precedence();
        int w0 = wr_cnt, d0 = done_cnt, t0 = to_cnt;
        issue(8'h01, 8'h02, 6'h03);
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        for (int i = 0; i < 40 && cyc < last_wr_cyc + TO; i++) tick();
        rxq.push_back(8'h5D);
        for (int i = 0; i < 10 && done_cnt == d0 && to_cnt == t0; i++) tick();
        tick();
        n_cmp++;
        if (to_cnt !== t0 || done_cnt - d0 !== 1 || result !== 8'h5D) begin
            n_err++;
            $display("FAIL last_cycle_byte: got to=%0d done=%0d result=%h expected 0 1 5d",
                     to_cnt - t0, done_cnt - d0, result);
        end
    endtask

    task automatic test_stale_flush();
        int w0 = wr_cnt, d0 = done_cnt, r0 = rd_cnt;
        rxq.push_back(8'h77);
        rxq.push_back(8'h66);
        txq.push_back(8'hC1); txq.push_back(8'h1C); txq.push_back(8'h2A);
        a = 8'hC1; b = 8'h1C; op = 6'h2A; start = 1'b1;
        tick();
        for (int i = 0; i < 10 && !busy; i++) tick();
        start = 1'b0;
        n_cmp++;
        if (rd_cnt - r0 !== 2 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pops: got pops=%0d busy=%b expected 2 1", rd_cnt - r0, busy);
        end
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        rxq.push_back(8'h11);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick();
        n_cmp++;
        if (result !== 8'h11 || rd_cnt - r0 !== 3) begin
            n_err++;
            $display("FAIL flush_result: got result=%h pops=%0d expected 11 3", result, rd_cnt - r0);
        end
    endtask

    task automatic test_busy_ignore();
        int w0 = wr_cnt, d0 = done_cnt;
        issue(8'h12, 8'h34, 6'h3F);
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        a = 8'hFF; b = 8'hEE; op = 6'h01; start = 1'b1;
        tick(); tick();
        start = 1'b0;
        tick();
        rxq.push_back(8'h9A);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick(); tick(); tick();
        n_cmp++;
        if (wr_cnt !== w0 + 3 || result !== 8'h9A || busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore: got writes=%0d result=%h busy=%b expected 3 9a 0",
                     wr_cnt - w0, result, busy);
        end
    endtask

    task automatic test_reset_mid();
        int w0 = wr_cnt, d0 = done_cnt;
        issue(8'h3C, 8'hC3, 6'h15);
        for (int i = 0; i < 20 && wr_cnt < w0 + 2; i++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, wr, rd, done, tmo} !== 5'b0 || w_data !== 8'h00 || result !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: got flags=%b w_data=%h result=%h expected 00000 00 00",
                     {busy, wr, rd, done, tmo}, w_data, result);
        end
        txq.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        w0 = wr_cnt;
        issue(8'hB7, 8'h7B, 6'h0C);
        for (int i = 0; i < 20 && wr_cnt < w0 + 3; i++) tick();
        rxq.push_back(8'hE1);
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        tick();
        n_cmp++;
        if (wr_cnt !== w0 + 3 || result !== 8'hE1) begin
            n_err++;
            $display("FAIL post_reset: got writes=%0d result=%h expected 3 e1", wr_cnt - w0, result);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_timeout();
        test_timeout_precedence();
        test_stale_flush();
        test_busy_ignore();
        test_reset_mid();
        tick(); tick();
        n_cmp++;
        if (txq.size() !== 0) begin
            n_err++;
            $display("FAIL tx_leftover: got %0d pending bytes expected 0", txq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
